// File: rtl/riscv_core_data_mem_arb_if.sv
// Bundle of both requester ports and the data-memory port of riscv_core_data_mem_arb.
// The lock inputs exist only when DATA_MEM_ARB_LOCK_EN is defined.
interface riscv_core_data_mem_arb_if #(
    parameter int XLEN = 64
);
    logic            i_data_mem_arb_req0_valid;
    logic            o_data_mem_arb_req0_ready;
    logic            i_data_mem_arb_req0_w_en;
    logic            i_data_mem_arb_req0_ld_extend;
    logic [1:0]      i_data_mem_arb_req0_size;
    logic [XLEN-1:0] i_data_mem_arb_req0_address;
    logic [XLEN-1:0] i_data_mem_arb_req0_wdata;
    logic            o_data_mem_arb_req0_rvalid;
    logic [XLEN-1:0] o_data_mem_arb_req0_rdata;

    logic            i_data_mem_arb_req1_valid;
    logic            o_data_mem_arb_req1_ready;
    logic            i_data_mem_arb_req1_w_en;
    logic            i_data_mem_arb_req1_ld_extend;
    logic [1:0]      i_data_mem_arb_req1_size;
    logic [XLEN-1:0] i_data_mem_arb_req1_address;
    logic [XLEN-1:0] i_data_mem_arb_req1_wdata;
    logic            o_data_mem_arb_req1_rvalid;
    logic [XLEN-1:0] o_data_mem_arb_req1_rdata;

`ifdef DATA_MEM_ARB_LOCK_EN
    logic            i_data_mem_arb_req0_lock;
    logic            i_data_mem_arb_req1_lock;
`endif

    logic            o_data_mem_arb_mem_w_en;
    logic            o_data_mem_arb_mem_ld_extend;
    logic [1:0]      o_data_mem_arb_mem_r_w_size;
    logic [XLEN-1:0] o_data_mem_arb_mem_address;
    logic [XLEN-1:0] o_data_mem_arb_mem_wdata;
    logic [XLEN-1:0] i_data_mem_arb_mem_rdata;

    // Arbiter side
    modport slave (
`ifdef DATA_MEM_ARB_LOCK_EN
        input  i_data_mem_arb_req0_lock, i_data_mem_arb_req1_lock,
`endif
        input  i_data_mem_arb_req0_valid, i_data_mem_arb_req0_w_en, i_data_mem_arb_req0_ld_extend,
        input  i_data_mem_arb_req0_size, i_data_mem_arb_req0_address, i_data_mem_arb_req0_wdata,
        output o_data_mem_arb_req0_ready, o_data_mem_arb_req0_rvalid, o_data_mem_arb_req0_rdata,
        input  i_data_mem_arb_req1_valid, i_data_mem_arb_req1_w_en, i_data_mem_arb_req1_ld_extend,
        input  i_data_mem_arb_req1_size, i_data_mem_arb_req1_address, i_data_mem_arb_req1_wdata,
        output o_data_mem_arb_req1_ready, o_data_mem_arb_req1_rvalid, o_data_mem_arb_req1_rdata,
        output o_data_mem_arb_mem_w_en, o_data_mem_arb_mem_ld_extend, o_data_mem_arb_mem_r_w_size,
        output o_data_mem_arb_mem_address, o_data_mem_arb_mem_wdata,
        input  i_data_mem_arb_mem_rdata
    );

    // Requester and memory side
    modport master (
`ifdef DATA_MEM_ARB_LOCK_EN
        output i_data_mem_arb_req0_lock, i_data_mem_arb_req1_lock,
`endif
        output i_data_mem_arb_req0_valid, i_data_mem_arb_req0_w_en, i_data_mem_arb_req0_ld_extend,
        output i_data_mem_arb_req0_size, i_data_mem_arb_req0_address, i_data_mem_arb_req0_wdata,
        input  o_data_mem_arb_req0_ready, o_data_mem_arb_req0_rvalid, o_data_mem_arb_req0_rdata,
        output i_data_mem_arb_req1_valid, i_data_mem_arb_req1_w_en, i_data_mem_arb_req1_ld_extend,
        output i_data_mem_arb_req1_size, i_data_mem_arb_req1_address, i_data_mem_arb_req1_wdata,
        input  o_data_mem_arb_req1_ready, o_data_mem_arb_req1_rvalid, o_data_mem_arb_req1_rdata,
        input  o_data_mem_arb_mem_w_en, o_data_mem_arb_mem_ld_extend, o_data_mem_arb_mem_r_w_size,
        input  o_data_mem_arb_mem_address, o_data_mem_arb_mem_wdata,
        output i_data_mem_arb_mem_rdata
    );
endinterface

// File: rtl/riscv_core_data_mem_arb.sv
// Round-robin two-requester arbiter and single-access sequencer for riscv_core_data_mem.
// Optional grant locking for read-modify-write sequences: DATA_MEM_ARB_LOCK_EN.
module riscv_core_data_mem_arb #(
    parameter int XLEN = 64
) (
    input  logic                       i_data_mem_arb_clk,
    input  logic                       i_data_mem_arb_rst,
    riscv_core_data_mem_arb_if.slave   io_bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_grant;
    logic            r_owner;
    logic            r_w_en;
    logic            r_ld_extend;
    logic [1:0]      r_size;
    logic [XLEN-1:0] r_address;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic            w_elig0;
    logic            w_elig1;
    logic            w_grant_valid;
    logic            w_grant_id;
    logic            w_accept;
`ifdef DATA_MEM_ARB_LOCK_EN
    logic            r_lock_active;
    logic            r_lock_owner;
    logic            w_grant_lock;
`endif

    // Eligibility: a held lock shuts out the other requester
    always_comb begin
`ifdef DATA_MEM_ARB_LOCK_EN
        w_elig0      = io_bus.i_data_mem_arb_req0_valid && !(r_lock_active && r_lock_owner);
        w_elig1      = io_bus.i_data_mem_arb_req1_valid && !(r_lock_active && !r_lock_owner);
        w_grant_lock = w_grant_id ? io_bus.i_data_mem_arb_req1_lock : io_bus.i_data_mem_arb_req0_lock;
`else
        w_elig0 = io_bus.i_data_mem_arb_req0_valid;
        w_elig1 = io_bus.i_data_mem_arb_req1_valid;
`endif
    end

    // Round-robin winner selection; ties go to the requester not granted last
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_last_grant;
        end else if (w_elig0) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b0;
        end else if (w_elig1) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b1;
        end else begin
            w_grant_valid = 1'b0;
            w_grant_id    = 1'b0;
        end
        w_accept = w_grant_valid && !i_data_mem_arb_rst &&
                   ((r_state == S_IDLE) || (r_state == S_RESP));
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = w_grant_valid ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = w_grant_valid ? S_ACCESS : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State, latched request fields, response capture
    always_ff @(posedge i_data_mem_arb_clk) begin
        if (i_data_mem_arb_rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_w_en       <= 1'b0;
            r_ld_extend  <= 1'b0;
            r_size       <= 2'b00;
            r_address    <= {XLEN{1'b0}};
            r_wdata      <= {XLEN{1'b0}};
            r_rdata      <= {XLEN{1'b0}};
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
`ifdef DATA_MEM_ARB_LOCK_EN
            r_lock_active <= 1'b0;
            r_lock_owner  <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_rvalid0 <= (r_state == S_ACCESS) && !r_owner;
            r_rvalid1 <= (r_state == S_ACCESS) && r_owner;
            if (r_state == S_ACCESS) begin
                r_rdata <= r_w_en ? {XLEN{1'b0}} : io_bus.i_data_mem_arb_mem_rdata;
            end
            if (w_accept) begin
                r_owner      <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_w_en       <= w_grant_id ? io_bus.i_data_mem_arb_req1_w_en      : io_bus.i_data_mem_arb_req0_w_en;
                r_ld_extend  <= w_grant_id ? io_bus.i_data_mem_arb_req1_ld_extend : io_bus.i_data_mem_arb_req0_ld_extend;
                r_size       <= w_grant_id ? io_bus.i_data_mem_arb_req1_size      : io_bus.i_data_mem_arb_req0_size;
                r_address    <= w_grant_id ? io_bus.i_data_mem_arb_req1_address   : io_bus.i_data_mem_arb_req0_address;
                r_wdata      <= w_grant_id ? io_bus.i_data_mem_arb_req1_wdata     : io_bus.i_data_mem_arb_req0_wdata;
`ifdef DATA_MEM_ARB_LOCK_EN
                r_lock_active <= w_grant_lock;
                r_lock_owner  <= w_grant_id;
`endif
            end
        end
    end

    assign io_bus.o_data_mem_arb_req0_ready   = w_accept && !w_grant_id;
    assign io_bus.o_data_mem_arb_req1_ready   = w_accept && w_grant_id;
    assign io_bus.o_data_mem_arb_req0_rvalid  = r_rvalid0;
    assign io_bus.o_data_mem_arb_req1_rvalid  = r_rvalid1;
    assign io_bus.o_data_mem_arb_req0_rdata   = r_rdata;
    assign io_bus.o_data_mem_arb_req1_rdata   = r_rdata;
    // A reset landing on the ACCESS cycle must not let the store commit
    assign io_bus.o_data_mem_arb_mem_w_en     = (r_state == S_ACCESS) && r_w_en && !i_data_mem_arb_rst;
    assign io_bus.o_data_mem_arb_mem_ld_extend = r_ld_extend;
    assign io_bus.o_data_mem_arb_mem_r_w_size = r_size;
    assign io_bus.o_data_mem_arb_mem_address  = r_address;
    assign io_bus.o_data_mem_arb_mem_wdata    = r_wdata;
endmodule
